// File: rtl/load_store_queue.sv
// In-order load/store queue: entries allocated at dispatch, filled by ROB id from the
// reservation station, executed from the head through a single-outstanding memory port.
module load_store_queue #(
  parameter int DEPTH = 16,
  parameter int PTR_W = 4
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic        _clear,
  input  logic        _alloc_valid,
  input  logic [4:0]  _alloc_rob_id,
  input  logic [3:0]  _alloc_type,
  output logic        _lsq_full,
  input  logic        _lsb_rs_ready,
  input  logic [4:0]  _lsb_rob_id,
  input  logic [31:0] _lsb_st_value,
  input  logic [31:0] _lsb_ptr_value,
  input  logic        _rob_commit_store,
  input  logic [4:0]  _rob_commit_rob_id,
  output logic        _st_ready,
  output logic [4:0]  _st_rob_id,
  output logic        _mem_req,
  output logic        _mem_we,
  output logic [31:0] _mem_addr,
  output logic [1:0]  _mem_size,
  output logic [31:0] _mem_wdata,
  input  logic        _mem_done,
  input  logic [31:0] _mem_rdata,
  output logic        _cdb_ls_ready,
  output logic [4:0]  _cdb_ls_rob_id,
  output logic [31:0] _cdb_ls_value
);

  // Memory handshake: _mem_req is raised with all fields stable and held until the
  // one-cycle _mem_done pulse; the request drops on the edge that samples _mem_done.
  typedef enum logic {S_IDLE, S_WAIT} state_t;
  localparam logic [PTR_W:0] DEPTH_C = DEPTH[PTR_W:0];

  state_t state, state_next;

  logic              e_valid     [DEPTH];
  logic [4:0]        e_rob_id    [DEPTH];
  logic [3:0]        e_type      [DEPTH];
  logic              e_addr_rdy  [DEPTH];
  logic [31:0]       e_addr      [DEPTH];
  logic [31:0]       e_data      [DEPTH];
  logic              e_committed [DEPTH];

  logic [PTR_W-1:0]  head, tail, idx;
  logic [PTR_W:0]    count, ncommit;
  logic              discard, run;
  logic [4:0]        ws_rob_id;
  logic [2:0]        ws_funct3;
  logic              full, pop, alloc_ok, head_ok, issue, fill_store, head_commit;
  logic [31:0]       load_val;

  assign full        = (count == DEPTH_C);
  assign _lsq_full   = full;
  assign pop         = (state == S_WAIT) && _mem_done && !discard;
  assign alloc_ok    = _alloc_valid && !_clear && (!full || pop);
  assign head_commit = e_valid[head] && e_committed[head];
  assign head_ok     = e_valid[head] && e_addr_rdy[head] &&
                       (!e_type[head][3] || e_committed[head]);
  assign issue       = (state == S_IDLE) && head_ok && !_clear;

  // Committed stores form a contiguous run from the head; a flush keeps exactly that run.
  always_comb begin
    ncommit    = '0;
    run        = 1'b1;
    idx        = '0;
    fill_store = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head + PTR_W'(i);
      if (run && ((PTR_W+1)'(i) < count) && e_valid[idx] && e_committed[idx])
        ncommit = ncommit + 1'b1;
      else
        run = 1'b0;
      if (_lsb_rs_ready && !_clear && e_valid[i] && e_type[i][3] &&
          e_rob_id[i] == _lsb_rob_id)
        fill_store = 1'b1;
    end
  end

  always_comb begin
    case (ws_funct3)
      3'b000:  load_val = {{24{_mem_rdata[7]}}, _mem_rdata[7:0]};
      3'b001:  load_val = {{16{_mem_rdata[15]}}, _mem_rdata[15:0]};
      3'b100:  load_val = {24'd0, _mem_rdata[7:0]};
      3'b101:  load_val = {16'd0, _mem_rdata[15:0]};
      default: load_val = _mem_rdata;
    endcase
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (issue) state_next = S_WAIT;
      S_WAIT:  if (_mem_done) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state         <= S_IDLE;
      head          <= '0;
      tail          <= '0;
      count         <= '0;
      discard       <= 1'b0;
      ws_rob_id     <= '0;
      ws_funct3     <= '0;
      _st_ready     <= 1'b0;
      _st_rob_id    <= '0;
      _mem_req      <= 1'b0;
      _mem_we       <= 1'b0;
      _mem_addr     <= '0;
      _mem_size     <= '0;
      _mem_wdata    <= '0;
      _cdb_ls_ready <= 1'b0;
      _cdb_ls_rob_id <= '0;
      _cdb_ls_value <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        e_valid[i]     <= 1'b0;
        e_rob_id[i]    <= '0;
        e_type[i]      <= '0;
        e_addr_rdy[i]  <= 1'b0;
        e_addr[i]      <= '0;
        e_data[i]      <= '0;
        e_committed[i] <= 1'b0;
      end
    end else if (rdy_in) begin
      state <= state_next;

      if (_clear) begin
        for (int i = 0; i < DEPTH; i++)
          if (!e_committed[i]) e_valid[i] <= 1'b0;
      end else begin
        for (int i = 0; i < DEPTH; i++) begin
          if (_lsb_rs_ready && e_valid[i] && e_rob_id[i] == _lsb_rob_id) begin
            e_addr[i]     <= _lsb_ptr_value;
            e_data[i]     <= _lsb_st_value;
            e_addr_rdy[i] <= 1'b1;
          end
          if (_rob_commit_store && e_valid[i] && e_type[i][3] &&
              e_rob_id[i] == _rob_commit_rob_id)
            e_committed[i] <= 1'b1;
        end
      end

      // Pop before alloc: when full, the popped slot is the one being refilled.
      if (pop) e_valid[head] <= 1'b0;
      if (alloc_ok) begin
        e_valid[tail]     <= 1'b1;
        e_rob_id[tail]    <= _alloc_rob_id;
        e_type[tail]      <= _alloc_type;
        e_addr_rdy[tail]  <= 1'b0;
        e_committed[tail] <= 1'b0;
      end

      if (_clear) begin
        head  <= head + PTR_W'(pop);
        tail  <= head + ncommit[PTR_W-1:0] + PTR_W'(pop && !head_commit);
        count <= ncommit - (PTR_W+1)'(pop && head_commit);
      end else begin
        if (pop)      head <= head + 1'b1;
        if (alloc_ok) tail <= tail + 1'b1;
        count <= count + (PTR_W+1)'(alloc_ok) - (PTR_W+1)'(pop);
      end

      if (issue) begin
        _mem_req   <= 1'b1;
        _mem_we    <= e_type[head][3];
        _mem_addr  <= e_addr[head];
        _mem_size  <= e_type[head][1:0];
        _mem_wdata <= e_data[head];
        ws_rob_id  <= e_rob_id[head];
        ws_funct3  <= e_type[head][2:0];
      end else if (state == S_WAIT && _mem_done) begin
        _mem_req <= 1'b0;
      end

      if (state == S_WAIT && _mem_done)
        discard <= 1'b0;
      else if (_clear && state == S_WAIT && !_mem_we)
        discard <= 1'b1;

      _cdb_ls_ready <= pop && !_mem_we && !_clear;
      if (pop && !_mem_we) begin
        _cdb_ls_rob_id <= ws_rob_id;
        _cdb_ls_value  <= load_val;
      end

      _st_ready <= fill_store;
      if (fill_store) _st_rob_id <= _lsb_rob_id;
    end
  end

endmodule

// File: tb/tb_load_store_queue.sv
// Directed bench for load_store_queue: load/store execution, sign extension, flush
// handling of in-flight loads and committed stores, and full/wrap-around behaviour.
module tb_load_store_queue;

  localparam logic [3:0] T_LB  = 4'b0000;
  localparam logic [3:0] T_LBU = 4'b0100;
  localparam logic [3:0] T_LW  = 4'b0010;
  localparam logic [3:0] T_SW  = 4'b1010;

  logic        clk_in = 1'b0, rst_in = 1'b0, rdy_in = 1'b1, _clear = 1'b0;
  logic        _alloc_valid = 1'b0;
  logic [4:0]  _alloc_rob_id = '0;
  logic [3:0]  _alloc_type = '0;
  logic        _lsq_full;
  logic        _lsb_rs_ready = 1'b0;
  logic [4:0]  _lsb_rob_id = '0;
  logic [31:0] _lsb_st_value = '0, _lsb_ptr_value = '0;
  logic        _rob_commit_store = 1'b0;
  logic [4:0]  _rob_commit_rob_id = '0;
  logic        _st_ready;
  logic [4:0]  _st_rob_id;
  logic        _mem_req, _mem_we;
  logic [31:0] _mem_addr, _mem_wdata;
  logic [1:0]  _mem_size;
  logic        _mem_done = 1'b0;
  logic [31:0] _mem_rdata = '0;
  logic        _cdb_ls_ready;
  logic [4:0]  _cdb_ls_rob_id;
  logic [31:0] _cdb_ls_value;

  int checks = 0, errors = 0;
  int req_cycles = 0, cdb_cnt = 0;
  logic [31:0] exp_q[$];

  load_store_queue #(.DEPTH(16), .PTR_W(4)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), ._clear(_clear),
    ._alloc_valid(_alloc_valid), ._alloc_rob_id(_alloc_rob_id), ._alloc_type(_alloc_type),
    ._lsq_full(_lsq_full),
    ._lsb_rs_ready(_lsb_rs_ready), ._lsb_rob_id(_lsb_rob_id),
    ._lsb_st_value(_lsb_st_value), ._lsb_ptr_value(_lsb_ptr_value),
    ._rob_commit_store(_rob_commit_store), ._rob_commit_rob_id(_rob_commit_rob_id),
    ._st_ready(_st_ready), ._st_rob_id(_st_rob_id),
    ._mem_req(_mem_req), ._mem_we(_mem_we), ._mem_addr(_mem_addr),
    ._mem_size(_mem_size), ._mem_wdata(_mem_wdata),
    ._mem_done(_mem_done), ._mem_rdata(_mem_rdata),
    ._cdb_ls_ready(_cdb_ls_ready), ._cdb_ls_rob_id(_cdb_ls_rob_id),
    ._cdb_ls_value(_cdb_ls_value)
  );

  // Clock and activity monitor
  always #5 clk_in = ~clk_in;

  always @(negedge clk_in) begin
    if (_mem_req)      req_cycles++;
    if (_cdb_ls_ready) cdb_cnt++;
  end

  initial begin
    #400000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1);
  end

  // Driver tasks
  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic alloc(input logic [4:0] rob, input logic [3:0] typ);
    _alloc_valid = 1'b1; _alloc_rob_id = rob; _alloc_type = typ;
    step();
    _alloc_valid = 1'b0;
  endtask

  task automatic fill(input logic [4:0] rob, input logic [31:0] addr, input logic [31:0] data);
    _lsb_rs_ready = 1'b1; _lsb_rob_id = rob; _lsb_ptr_value = addr; _lsb_st_value = data;
    step();
    _lsb_rs_ready = 1'b0;
  endtask

  task automatic commit(input logic [4:0] rob);
    _rob_commit_store = 1'b1; _rob_commit_rob_id = rob;
    step();
    _rob_commit_store = 1'b0;
  endtask

  task automatic wait_req(input string tag);
    int n = 0;
    while (!_mem_req && n < 20) begin
      step();
      n++;
    end
    chk({tag, "_req"}, 32'(_mem_req), 32'd1);
  endtask

  task automatic mem_complete(input logic [31:0] rdata);
    _mem_done = 1'b1; _mem_rdata = rdata;
    step();
    _mem_done = 1'b0;
  endtask

  initial begin
    logic [31:0] exp;
    // Reset
    repeat (3) step();
    chk("rst_full", 32'(_lsq_full), 32'd0);
    chk("rst_req", 32'(_mem_req), 32'd0);
    chk("rst_cdb", 32'(_cdb_ls_ready), 32'd0);
    chk("rst_st", 32'(_st_ready), 32'd0);
    rst_in = 1'b1;
    step();

    // LW with 3-cycle memory latency
    alloc(5'd3, T_LW);
    fill(5'd3, 32'h100, 32'h0);
    req_cycles = 0; cdb_cnt = 0;
    wait_req("lw");
    chk("lw_we", 32'(_mem_we), 32'd0);
    chk("lw_addr", _mem_addr, 32'h100);
    chk("lw_size", 32'(_mem_size), 32'd2);
    repeat (2) step();
    mem_complete(32'hDEADBEEF);
    chk("lw_cdb_rdy", 32'(_cdb_ls_ready), 32'd1);
    chk("lw_cdb_rob", 32'(_cdb_ls_rob_id), 32'd3);
    chk("lw_cdb_val", _cdb_ls_value, 32'hDEADBEEF);
    step();
    chk("lw_cdb_low", 32'(_cdb_ls_ready), 32'd0);
    chk("lw_req_cycles", 32'(req_cycles), 32'd3);
    chk("lw_cdb_cnt", 32'(cdb_cnt), 32'd1);

    // LB sign extension, then LBU zero extension
    alloc(5'd5, T_LB);
    fill(5'd5, 32'h20, 32'h0);
    wait_req("lb");
    chk("lb_addr", _mem_addr, 32'h20);
    chk("lb_size", 32'(_mem_size), 32'd0);
    mem_complete(32'h00000080);
    chk("lb_cdb_rob", 32'(_cdb_ls_rob_id), 32'd5);
    chk("lb_val", _cdb_ls_value, 32'hFFFFFF80);
    alloc(5'd5, T_LBU);
    fill(5'd5, 32'h20, 32'h0);
    wait_req("lbu");
    mem_complete(32'h00000080);
    chk("lbu_rdy", 32'(_cdb_ls_ready), 32'd1);
    chk("lbu_val", _cdb_ls_value, 32'h00000080);
    step();

    // SW waits for commit
    alloc(5'd7, T_SW);
    fill(5'd7, 32'h40, 32'h12345678);
    chk("sw_st_ready", 32'(_st_ready), 32'd1);
    chk("sw_st_rob", 32'(_st_rob_id), 32'd7);
    req_cycles = 0;
    step();
    chk("sw_st_pulse", 32'(_st_ready), 32'd0);
    repeat (3) step();
    chk("sw_no_req", 32'(req_cycles), 32'd0);
    commit(5'd7);
    wait_req("sw");
    chk("sw_we", 32'(_mem_we), 32'd1);
    chk("sw_addr", _mem_addr, 32'h40);
    chk("sw_wdata", _mem_wdata, 32'h12345678);
    chk("sw_size", 32'(_mem_size), 32'd2);
    mem_complete(32'h0);
    chk("sw_no_cdb", 32'(_cdb_ls_ready), 32'd0);
    step();

    // Flush while a committed store is in flight
    cdb_cnt = 0;
    alloc(5'd1, T_SW);
    alloc(5'd2, T_LW);
    alloc(5'd3, T_LW);
    fill(5'd1, 32'h200, 32'hCAFE0001);
    fill(5'd2, 32'h204, 32'h0);
    fill(5'd3, 32'h208, 32'h0);
    commit(5'd1);
    wait_req("fst");
    chk("fst_we", 32'(_mem_we), 32'd1);
    _clear = 1'b1;
    step();
    _clear = 1'b0;
    chk("fst_req_held", 32'(_mem_req), 32'd1);
    chk("fst_addr_held", _mem_addr, 32'h200);
    mem_complete(32'h0);
    req_cycles = 0;
    repeat (6) step();
    chk("fst_no_more_req", 32'(req_cycles), 32'd0);
    chk("fst_no_cdb", 32'(cdb_cnt), 32'd0);

    // Flush while a load is in flight: its completion is discarded
    cdb_cnt = 0;
    alloc(5'd4, T_LW);
    fill(5'd4, 32'h80, 32'h0);
    wait_req("fld");
    _clear = 1'b1;
    step();
    _clear = 1'b0;
    mem_complete(32'h55);
    chk("fld_no_cdb", 32'(_cdb_ls_ready), 32'd0);
    alloc(5'd6, T_LW);
    fill(5'd6, 32'h84, 32'h0);
    wait_req("fld_next");
    chk("fld_next_addr", _mem_addr, 32'h84);
    mem_complete(32'h66);
    chk("fld_next_rob", 32'(_cdb_ls_rob_id), 32'd6);
    chk("fld_next_val", _cdb_ls_value, 32'h66);
    step();
    chk("fld_cdb_cnt", 32'(cdb_cnt), 32'd1);

    // Fill to capacity, pop+alloc in one cycle, then drain across the wrap
    for (int i = 0; i < 16; i++) begin
      alloc(5'(i), T_LW);
      if (i == 14) chk("full_at_15", 32'(_lsq_full), 32'd0);
    end
    chk("full_at_16", 32'(_lsq_full), 32'd1);
    fill(5'd0, 32'h1000, 32'h0);
    wait_req("full_head");
    _mem_done = 1'b1; _mem_rdata = 32'hA0000000;
    _alloc_valid = 1'b1; _alloc_rob_id = 5'd16; _alloc_type = T_LW;
    step();
    _mem_done = 1'b0; _alloc_valid = 1'b0;
    chk("full_stays", 32'(_lsq_full), 32'd1);
    chk("full_cdb_rob", 32'(_cdb_ls_rob_id), 32'd0);
    chk("full_cdb_val", _cdb_ls_value, 32'hA0000000);
    for (int r = 1; r <= 16; r++) begin
      fill(5'(r), 32'h1000 + 32'(4 * r), 32'h0);
      exp_q.push_back(32'(r));
    end
    while (exp_q.size() > 0) begin
      exp = exp_q.pop_front();
      wait_req("drain");
      chk("drain_addr", _mem_addr, 32'h1000 + 4 * exp);
      mem_complete(32'hA0000000 + exp);
      chk("drain_rdy", 32'(_cdb_ls_ready), 32'd1);
      chk("drain_rob", 32'(_cdb_ls_rob_id), exp);
      chk("drain_val", _cdb_ls_value, 32'hA0000000 + exp);
    end
    step();
    chk("drain_not_full", 32'(_lsq_full), 32'd0);

    // Final report
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
